player_physics: RTL
===================

Name: player_physics

Overview:
- Next-generation player motion engine for the side-scroller. Replaces the VS-clocked movement block with a single-clock, frame-tick-enabled design.
- Adds parametrised coordinate and velocity widths, N platforms, signed velocity with saturating gravity, an explicit air/ground FSM, lives/respawn and game-over.
- Sits between the controller decode and the sprite renderer/scroller.

Parameters:
- COORD_W, 10, width of X/Y coordinates (unsigned)
- VEL_W, 8, width of signed Y velocity
- N_PLAT, 4, number of platforms checked per frame
- X_STEP, 2, horizontal pixels per frame
- GRAVITY, 1, velocity increment per gravity period
- GRAV_DIV, 3, frame ticks per gravity increment
- JUMP_V, 12, initial upward speed (magnitude)
- MAX_FALL, 8, downward velocity saturation
- X_MIN / SCROLL_X / Y_MAX, 20 / 320 / 479, left limit, scroll threshold, kill plane
- START_X / START_Y, 30 / 75, spawn and respawn position
- LIVES_INIT, 3, lives after reset

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-Clk strobe per video frame; all state advances only on it
- play_en  in  1  gameState==play; low freezes all state
- move_left, move_right, jump_btn  in  1 each  decoded controller levels
- player_w, player_h  in  COORD_W each  current sprite size
- plat_start, plat_end, plat_top  in  N_PLAT*COORD_W each  packed platform spans and top edges
- player_x, player_y  out  COORD_W each  top-left position (registered)
- vel_y  out  VEL_W  signed vertical velocity
- direction  out  1  0=right, 1=left
- on_ground, moving, scroll_en  out  1 each  status
- lives  out  2  remaining lives
- died  out  1  one-Clk pulse on a kill event
- game_over  out  1  sticky

Behaviour:
- Reset: x=START_X, y=START_Y, vel_y=0, direction=0, state=FALL, lives=LIVES_INIT, grav_cnt=0; all flags 0.
- Updates occur on the Clk edge where frame_tick=1 and play_en=1. Outputs change 1 Clk after the tick and are otherwise held.
- Horizontal:
  - move_left sets direction=1; x-=X_STEP unless x<=X_MIN (then held).
  - move_right sets direction=0; if x>=SCROLL_X, x is held and scroll_en=1 for that frame, else x+=X_STEP.
  - Both or neither pressed: no X motion.
  - moving = horizontal motion or state!=GROUND.
- Feet = y+player_h. Centre = x+(player_w>>1).
- Support test (platform i): plat_start<=centre<=plat_end and feet==plat_top.
- Landing test: vel_y>=0, old feet<=plat_top, new feet>=plat_top. On a hit, y snaps to plat_top-player_h.
  - Lowest index wins.
  - Comparisons use COORD_W+1 bits; no wrap.
- FSM states: GROUND, RISE, FALL, DEAD.
  - GROUND: vel_y=0, on_ground=1. Jump-edge → RISE with vel_y=-JUMP_V. No supporting platform → FALL with vel_y=0.
  - RISE/FALL: grav_cnt counts ticks 0..GRAV_DIV-1. On wrap, vel_y+=GRAVITY, saturating at +MAX_FALL. y+=vel_y (signed add). RISE→FALL when vel_y>=0. Landing hit → GROUND.
  - Any state with y>Y_MAX or x>=2^COORD_W-X_STEP → DEAD. Kill takes priority over landing.
  - DEAD (one tick): died=1; if lives==0, game_over=1 and remain DEAD; else lives-=1, position=START, vel_y=0, state=FALL.
- Jump-edge: jump_btn sampled at each tick; edge = sample 1 while the previous sample was 0. Holding the button never re-jumps.
- Simultaneous jump and leaving the edge on the same tick: the jump wins.
- play_en low: no updates, and the jump sample is not updated.
- Reset mid-air: immediate return to reset values.

Optional Feature:
- Macro: PLAYER_DOUBLE_JUMP_EN.
- Defined: one extra jump-edge is allowed while in RISE/FALL. It sets vel_y=-JUMP_V and state=RISE. An air_jump_used flag is cleared on entering GROUND or on respawn.
- Undefined: jump-edges in the air are ignored; no flag is generated.

Decomposition:
- Package contra_phys_pkg: FSM enum phys_state_t {GROUND,RISE,FALL,DEAD}, direction constants DIR_RIGHT/DIR_LEFT, velocity saturation function.
- Sub-module platform_hit_detect: purely combinational. Takes the N_PLAT packed spans, centre, old/new feet and vel_y sign. Outputs supported, landed and snap_y.

Test Plan:
1. Reset release, no inputs, platform 0 top=200 spanning 0..639, player_h=32 → falls, lands with y=168, on_ground=1, vel_y=0.
2. Grounded at x=300, move_right held 20 ticks → x reaches 320 after 10 ticks and holds; scroll_en=1 on every later tick.
3. Grounded, jump_btn pulse → vel_y=-12 next tick. Apex when vel_y reaches 0 after 36 ticks (GRAV_DIV=3). Relands at y=168; holding jump_btn causes no second jump.
4. Walk left off platform end → FALL. vel_y saturates at 8. y exceeds 479 → died pulse, lives 3→2, position 30,75.
5. Four kills from lives=3 → game_over=1; frozen thereafter until Reset.
6. Reset asserted mid-RISE; play_en low for 5 ticks → outputs return to reset values; frozen ticks change nothing. With PLAYER_DOUBLE_JUMP_EN, a second airborne jump succeeds and a third is ignored.

Source files
------------

// File: rtl/contra_phys_pkg.sv
// rtl/contra_phys_pkg.sv - shared types and helpers for the player motion engine
//
// Contents:
//   phys_state_t          air/ground FSM encoding
//   DIR_RIGHT / DIR_LEFT  values driven on the direction output
//   sat_vel               velocity increment with an upper (downward) limit
package contra_phys_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        DEAD   = 2'd3
    } phys_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Gravity only ever pushes velocity downward (positive), so a single
    // upper clamp is enough.
    function automatic int sat_vel(input int v, input int inc, input int max_v);
        return (v + inc > max_v) ? max_v : v + inc;
    endfunction

endpackage

// File: rtl/platform_hit_detect.sv
// rtl/platform_hit_detect.sv - combinational support/landing test against N platforms
//
// Ports:
//   plat_start/plat_end/plat_top  packed per-platform spans and top edges (index 0 in LSBs)
//   centre                        horizontal centre of the player after this frame's X move
//   old_feet/new_feet             feet row before and after this frame's Y move
//   player_h                      sprite height, used to derive the snapped top-left Y
//   vel_neg                       vertical velocity is upward (no landing possible)
//   supported                     some platform lies exactly under the current feet
//   landed                        feet crossed a platform top this frame
//   snap_y                        top-left Y that puts the feet on the landed platform
module platform_hit_detect #(
    parameter int COORD_W = 10,
    parameter int N_PLAT  = 4
) (
    input  logic [N_PLAT*COORD_W-1:0] plat_start,
    input  logic [N_PLAT*COORD_W-1:0] plat_end,
    input  logic [N_PLAT*COORD_W-1:0] plat_top,
    input  logic [COORD_W:0]          centre,
    input  logic [COORD_W:0]          old_feet,
    input  logic [COORD_W:0]          new_feet,
    input  logic [COORD_W-1:0]        player_h,
    input  logic                      vel_neg,
    output logic                      supported,
    output logic                      landed,
    output logic [COORD_W-1:0]        snap_y
);

    logic [COORD_W:0] top_w;
    logic             in_span;

    // Scanning from the highest index down lets the lowest index overwrite last.
    always_comb begin
        supported = 1'b0;
        landed    = 1'b0;
        snap_y    = '0;
        top_w     = '0;
        in_span   = 1'b0;
        for (int i = N_PLAT - 1; i >= 0; i--) begin
            top_w   = {1'b0, plat_top[i*COORD_W +: COORD_W]};
            in_span = ({1'b0, plat_start[i*COORD_W +: COORD_W]} <= centre) &&
                      (centre <= {1'b0, plat_end[i*COORD_W +: COORD_W]});
            if (in_span && (old_feet == top_w)) begin
                supported = 1'b1;
            end
            if (in_span && !vel_neg && (old_feet <= top_w) && (new_feet >= top_w)) begin
                landed = 1'b1;
                snap_y = COORD_W'(top_w - {1'b0, player_h});
            end
        end
    end

endmodule

// File: rtl/player_physics.sv
// rtl/player_physics.sv - frame-tick player motion engine with air/ground FSM and lives
//
// Optional build macro: PLAYER_DOUBLE_JUMP_EN (one extra jump while airborne).
//
// Ports:
//   Clk, Reset                    system clock, asynchronous active-low reset
//   frame_tick, play_en           state advances only on a tick while playing
//   move_left/move_right/jump_btn decoded controller levels
//   player_w, player_h            sprite size
//   plat_start/plat_end/plat_top  packed platform spans and top edges
//   player_x, player_y            top-left position
//   vel_y                         signed vertical velocity (positive = down)
//   direction                     0 = right, 1 = left
//   on_ground, moving, scroll_en  status flags
//   lives, died, game_over        life count, one-Clk kill pulse, sticky end flag
module player_physics
    import contra_phys_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int VEL_W      = 8,
    parameter int N_PLAT     = 4,
    parameter int X_STEP     = 2,
    parameter int GRAVITY    = 1,
    parameter int GRAV_DIV   = 3,
    parameter int JUMP_V     = 12,
    parameter int MAX_FALL   = 8,
    parameter int X_MIN      = 20,
    parameter int SCROLL_X   = 320,
    parameter int Y_MAX      = 479,
    parameter int START_X    = 30,
    parameter int START_Y    = 75,
    parameter int LIVES_INIT = 3
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_tick,
    input  logic                      play_en,
    input  logic                      move_left,
    input  logic                      move_right,
    input  logic                      jump_btn,
    input  logic [COORD_W-1:0]        player_w,
    input  logic [COORD_W-1:0]        player_h,
    input  logic [N_PLAT*COORD_W-1:0] plat_start,
    input  logic [N_PLAT*COORD_W-1:0] plat_end,
    input  logic [N_PLAT*COORD_W-1:0] plat_top,
    output logic [COORD_W-1:0]        player_x,
    output logic [COORD_W-1:0]        player_y,
    output logic signed [VEL_W-1:0]   vel_y,
    output logic                      direction,
    output logic                      on_ground,
    output logic                      moving,
    output logic                      scroll_en,
    output logic [1:0]                lives,
    output logic                      died,
    output logic                      game_over
);

    localparam int GC_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

    localparam logic [COORD_W-1:0]      X_MIN_C   = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0]      SCROLL_C  = COORD_W'(SCROLL_X);
    localparam logic [COORD_W-1:0]      Y_MAX_C   = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0]      START_X_C = COORD_W'(START_X);
    localparam logic [COORD_W-1:0]      START_Y_C = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0]      X_STEP_C  = COORD_W'(X_STEP);
    localparam logic [COORD_W:0]        X_KILL_C  = (COORD_W+1)'((1 << COORD_W) - X_STEP);
    localparam logic signed [VEL_W-1:0] JUMP_C    = VEL_W'(-JUMP_V);
    localparam logic [1:0]              LIVES_C   = 2'(LIVES_INIT);
    localparam logic [GC_W-1:0]         GC_LAST   = GC_W'(GRAV_DIV - 1);

    phys_state_t              state, state_n;
    logic [GC_W-1:0]          grav_cnt, grav_air, grav_n;
    logic                     jump_prev, jump_edge, upd, air_jump_ok;
    logic [COORD_W-1:0]       hx, x_n, y_n, y_air, snap_y;
    logic                     hmove, dir_h, scroll_h;
    logic                     dir_n, scroll_n, moving_h, moving_n, ground_n;
    logic                     died_n, go_n, kill;
    logic [1:0]               lives_n;
    logic signed [VEL_W-1:0]  vel_air, vel_n;
    logic signed [COORD_W+1:0] y_sum;
    logic [COORD_W:0]         centre, old_feet, new_feet;
    logic                     supported, landed;

    assign upd       = frame_tick && play_en && !game_over;
    assign jump_edge = jump_btn && !jump_prev;

    // Horizontal step; both or neither button leaves X alone.
    always_comb begin
        hx       = player_x;
        hmove    = 1'b0;
        dir_h    = direction;
        scroll_h = 1'b0;
        if (move_left && !move_right) begin
            dir_h = DIR_LEFT;
            if (player_x > X_MIN_C) begin
                hx    = player_x - X_STEP_C;
                hmove = 1'b1;
            end
        end else if (move_right && !move_left) begin
            dir_h = DIR_RIGHT;
            if (player_x >= SCROLL_C) begin
                scroll_h = 1'b1;
            end else begin
                hx    = player_x + X_STEP_C;
                hmove = 1'b1;
            end
        end
    end

    // Airborne vertical step. Rising past the top of the screen pins Y at 0
    // rather than wrapping into the kill plane.
    always_comb begin
        if (grav_cnt == GC_LAST) begin
            grav_air = '0;
            vel_air  = VEL_W'(sat_vel(int'(vel_y), GRAVITY, MAX_FALL));
        end else begin
            grav_air = grav_cnt + 1'b1;
            vel_air  = vel_y;
        end
        y_sum = $signed({2'b00, player_y}) +
                $signed({{(COORD_W+2-VEL_W){vel_air[VEL_W-1]}}, vel_air});
        if (y_sum < 0) begin
            y_air = '0;
        end else if (y_sum[COORD_W]) begin
            y_air = '1;
        end else begin
            y_air = y_sum[COORD_W-1:0];
        end
    end

    assign centre   = {1'b0, hx} + (COORD_W+1)'(player_w >> 1);
    assign old_feet = {1'b0, player_y} + {1'b0, player_h};
    assign new_feet = {1'b0, y_air} + {1'b0, player_h};

    platform_hit_detect #(
        .COORD_W (COORD_W),
        .N_PLAT  (N_PLAT)
    ) u_hit (
        .plat_start (plat_start),
        .plat_end   (plat_end),
        .plat_top   (plat_top),
        .centre     (centre),
        .old_feet   (old_feet),
        .new_feet   (new_feet),
        .player_h   (player_h),
        .vel_neg    (vel_air[VEL_W-1]),
        .supported  (supported),
        .landed     (landed),
        .snap_y     (snap_y)
    );

    always_comb begin
        state_n  = state;
        x_n      = player_x;
        y_n      = player_y;
        vel_n    = vel_y;
        grav_n   = grav_cnt;
        dir_n    = direction;
        scroll_n = 1'b0;
        moving_h = 1'b0;
        lives_n  = lives;
        died_n   = 1'b0;
        go_n     = 1'b0;
        case (state)
            GROUND: begin
                x_n      = hx;
                dir_n    = dir_h;
                scroll_n = scroll_h;
                moving_h = hmove;
                // Jump is checked first so it wins over walking off an edge.
                if (jump_edge) begin
                    state_n = RISE;
                    vel_n   = JUMP_C;
                    grav_n  = '0;
                end else if (!supported) begin
                    state_n = FALL;
                    vel_n   = '0;
                    grav_n  = '0;
                end
            end
            RISE, FALL: begin
                x_n      = hx;
                dir_n    = dir_h;
                scroll_n = scroll_h;
                moving_h = hmove;
                if (air_jump_ok) begin
                    state_n = RISE;
                    vel_n   = JUMP_C;
                    grav_n  = '0;
                end else begin
                    y_n    = y_air;
                    vel_n  = vel_air;
                    grav_n = grav_air;
                    if (landed) begin
                        state_n = GROUND;
                        y_n     = snap_y;
                        vel_n   = '0;
                        grav_n  = '0;
                    end else begin
                        state_n = vel_air[VEL_W-1] ? RISE : FALL;
                    end
                end
            end
            default: begin
                died_n = 1'b1;
                if (lives == 2'd0) begin
                    go_n = 1'b1;
                end else begin
                    lives_n = lives - 2'd1;
                    x_n     = START_X_C;
                    y_n     = START_Y_C;
                    vel_n   = '0;
                    grav_n  = '0;
                    state_n = FALL;
                end
            end
        endcase
        kill = (y_n > Y_MAX_C) || ({1'b0, x_n} >= X_KILL_C);
        if ((state != DEAD) && kill) begin
            state_n = DEAD;
        end
        ground_n = (state_n == GROUND);
        moving_n = moving_h || (state_n != GROUND);
    end

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic air_jump_used, air_jump_n;

    assign air_jump_ok = jump_edge && !air_jump_used && ((state == RISE) || (state == FALL));
    assign air_jump_n  = ((state_n == GROUND) || (state == DEAD)) ? 1'b0
                                                                  : (air_jump_used || air_jump_ok);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            air_jump_used <= 1'b0;
        end else if (upd) begin
            air_jump_used <= air_jump_n;
        end
    end
`else
    assign air_jump_ok = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= FALL;
            player_x  <= START_X_C;
            player_y  <= START_Y_C;
            vel_y     <= '0;
            grav_cnt  <= '0;
            direction <= DIR_RIGHT;
            on_ground <= 1'b0;
            moving    <= 1'b0;
            scroll_en <= 1'b0;
            lives     <= LIVES_C;
            died      <= 1'b0;
            game_over <= 1'b0;
            jump_prev <= 1'b0;
        end else begin
            died <= 1'b0;
            if (upd) begin
                state     <= state_n;
                player_x  <= x_n;
                player_y  <= y_n;
                vel_y     <= vel_n;
                grav_cnt  <= grav_n;
                direction <= dir_n;
                on_ground <= ground_n;
                moving    <= moving_n;
                scroll_en <= scroll_n;
                lives     <= lives_n;
                died      <= died_n;
                jump_prev <= jump_btn;
                if (go_n) begin
                    game_over <= 1'b1;
                end
            end
        end
    end

endmodule
